serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: the inverse of the full-adder datapath. One full-subtractor cell is reused for one bit per clock, LSB first, over WIDTH cycles.
- Computes a - b - bin. Returns a WIDTH-bit difference and a borrow-out.
- Sits beside the ripple adder in the arithmetic library. It is the area-minimal subtract path for ALU experiments.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 8, operand and difference width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b and bin are presented
- in_ready  output  1  block is IDLE and will accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff and bout hold a completed result
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  difference
- bout  output  1  borrow-out

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low; all state is cleared immediately on assertion.
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - diff = 0
  - bout = 0
  - bit counter = 0
  - internal shift registers = 0
- States: IDLE, RUN, DONE.
- in_ready = (state == IDLE), decoded from state. out_valid = (state == DONE), registered state decode.
- IDLE: on an edge with in_valid=1:
  - capture a into shift register sa and b into sb
  - borrow register br <= bin
  - counter <= 0
  - go to RUN
  - in_valid=0 keeps the block in IDLE.
- RUN, each edge:
  - Cell outputs: d = sa[0]^sb[0]^br; br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - Shift d into the MSB of result register sr (shift right). Shift sa and sb right by one. Counter increments.
  - On the edge where counter == WIDTH-1: diff <= final sr value including d, bout <= new borrow, go to DONE.
  - RUN therefore lasts exactly WIDTH edges.
- Latency: operands accepted at edge E0. Cell evaluates at edges E1..E_WIDTH. out_valid=1 from E_WIDTH onward.
- diff and bout do not change during RUN. They keep the previous result until the final RUN edge.
- DONE:
  - out_valid=1; diff and bout stable.
  - On an edge with out_ready=1: go to IDLE, out_valid falls.
  - diff and bout keep their value after the handoff; they are cleared only by reset.
- Throughput with out_ready tied high: one result per WIDTH+2 cycles (accept, WIDTH RUN edges, DONE handoff).
- Arithmetic result:
  - {bout, diff} = ({1'b0,a} - {1'b0,b} - bin) mod 2^(WIDTH+1).
  - bout=1 exactly when a < b + bin (unsigned comparison).
- Boundary conditions:
  - in_valid in RUN or DONE: ignored, since in_ready=0. Operands are not queued.
  - Operand inputs are sampled only at the accept edge. Changing a, b or bin during RUN has no effect.
  - out_ready in IDLE or RUN: ignored.
  - Counter width is clog2(WIDTH). There is no wrap beyond WIDTH-1.
  - Reset asserted mid-RUN or in DONE: immediate return to IDLE with the reset values above. The partial result is discarded.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, bin=0, out_ready=1 -> diff=0x37, bout=0; out_valid rises exactly 8 edges after the accept edge and stays high one cycle.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0. Then a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
- Backpressure: a=0xC3, b=0x41, out_ready held 0 for 5 cycles in DONE:
  - out_valid stays 1; diff=0x82 and bout=0 stay stable; in_ready=0.
  - in_valid=1 with a=0xFF is ignored.
  - Raising out_ready returns the block to IDLE with in_ready=1 on the next edge.
- Reset mid-operation: assert rst_n=0 after 3 RUN edges -> immediately in_ready=1, out_valid=0, diff=0x00, bout=0. A following op a=0x09, b=0x04 gives diff=0x05, bout=0.
- Input stability: change a and b every cycle during RUN -> result equals the values captured at the accept edge.
- WIDTH=4, exhaustive: all 512 combinations of {a, b, bin} back-to-back with out_ready=1 -> every {bout, diff} matches a reference model; the accept-to-accept period is exactly 6 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell reused LSB-first
// over WIDTH clocks, computing {bout, diff} = a - b - bin with valid/ready on both sides.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
    // in_ready is high only in IDLE, out_valid only in DONE, and neither depends on the
    // partner's valid/ready in the same cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_out_valid;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_sr_next;

    // Full-subtractor cell on the current LSBs
    assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_sr_next = {w_d, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sa        <= '0;
            r_sb        <= '0;
            r_sr        <= '0;
            r_br        <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sa <= r_sa >> 1;
                    r_sb <= r_sb >> 1;
                    r_sr <= w_sr_next;
                    r_br <= w_br_next;
                    // Counter saturates at LAST so it never wraps on power-of-two widths
                    if (r_cnt == LAST) begin
                        r_diff      <= w_sr_next;
                        r_bout      <= w_br_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign dbg_state = r_state;

endmodule
